// File: rtl/simd_lane_sequencer.sv
// Vector issue/collect stage: walks one lane per cycle through an external ALU.
// Optional SIMD_SEQ_BACK_TO_BACK_EN lets DONE hand straight over to ISSUE.
module simd_lane_sequencer #(
  parameter int dataSize = 8,
  parameter int lanes    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [lanes*dataSize-1:0] in_vec_a,
  input  logic [lanes*dataSize-1:0] in_vec_b,
  output logic [2:0]                alu_op,
  output logic [dataSize-1:0]       alu_a,
  output logic [dataSize-1:0]       alu_b,
  input  logic [dataSize-1:0]       alu_result,
  input  logic                      alu_neg,
  input  logic                      alu_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lanes*dataSize-1:0] out_vec,
  output logic                      out_any_neg,
  output logic                      out_all_zero
);

  localparam int VW = lanes * dataSize;
  localparam int CW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [CW-1:0] LAST = CW'(lanes - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [VW-1:0]  a_q, a_d;
  logic [VW-1:0]  b_q, b_d;
  logic [VW-1:0]  vec_q, vec_d;
  logic           neg_q, neg_d;
  logic           zero_q, zero_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vec_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    vec_d    = vec_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    in_ready = 1'b0;
    alu_op   = '0;
    alu_a    = '0;
    alu_b    = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      ISSUE: begin
        alu_op = op_q;
        alu_a  = a_q[int'(cnt_q)*dataSize +: dataSize];
        alu_b  = b_q[int'(cnt_q)*dataSize +: dataSize];
        vec_d[int'(cnt_q)*dataSize +: dataSize] = alu_result;
        neg_d  = neg_q | alu_neg;
        zero_d = zero_q & alu_zero;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
`ifdef SIMD_SEQ_BACK_TO_BACK_EN
        in_ready = out_ready;
`else
        in_ready = 1'b0;
`endif
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance overrides DONE->IDLE when the back-to-back path is open.
    if (in_ready && in_valid) begin
      op_d    = in_op;
      a_d     = in_vec_a;
      b_d     = in_vec_b;
      cnt_d   = '0;
      vec_d   = '0;
      neg_d   = 1'b0;
      zero_d  = 1'b1;
      state_d = ISSUE;
    end
  end

  assign out_valid    = (state_q == DONE);
  assign out_vec      = vec_q;
  assign out_any_neg  = neg_q;
  assign out_all_zero = zero_q;

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Bench for simd_lane_sequencer with a behavioural ALU and vector reference model.
// Directed add/sub/xor/backpressure/reset/throughput steps plus random ops.
module tb_simd_lane_sequencer;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int VW = DW * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [VW-1:0] in_vec_a;
  logic [VW-1:0] in_vec_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          alu_neg;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic          out_any_neg;
  logic          out_all_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  simd_lane_sequencer #(.dataSize(DW), .lanes(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_vec_a(in_vec_a), .in_vec_b(in_vec_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_any_neg(out_any_neg),
    .out_all_zero(out_all_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] alu_f(
    input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'b001:  return a ^ b;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b111:  return a + 8'd1;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_op, alu_a, alu_b);
    alu_neg    = alu_result[DW-1];
    alu_zero   = (alu_result == '0);
  end

  function automatic logic [VW-1:0] pk(input int l0, l1, l2, l3);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  function automatic logic [DW-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Reference: whole-vector result and reduced flags from the lane rules.
  function automatic logic [VW+1:0] ref_f(
    input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] v;
    logic          n;
    logic          z;
    logic [DW-1:0] r;
    v = '0;
    n = 1'b0;
    z = 1'b1;
    for (int i = 0; i < L; i++) begin
      r = alu_f(op, lane(a, i), lane(b, i));
      v[i*DW +: DW] = r;
      n = n | (r[DW-1] == 1'b1);
      z = z & (r == 0);
    end
    return {n, z, v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, follow it lane by lane, stop in DONE.
  task automatic issue(input logic [2:0] op, input logic [VW-1:0] a,
                       input logic [VW-1:0] b);
    logic [VW+1:0] e;
    int            n;
    e = ref_f(op, a, b);
    in_op    = op;
    in_vec_a = a;
    in_vec_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      check($sformatf("issue_op_l%0d", i), 64'(alu_op), 64'(op));
      check($sformatf("issue_a_l%0d", i), 64'(alu_a), 64'(lane(a, i)));
      check($sformatf("issue_b_l%0d", i), 64'(alu_b), 64'(lane(b, i)));
      check($sformatf("issue_busy_l%0d", i),
            64'({out_valid, in_ready}), 64'd0);
      step();
    end
    check("latency_valid", 64'(out_valid), 64'd1);
    check("out_vec", 64'(out_vec), 64'(e[VW-1:0]));
    check("out_all_zero", 64'(out_all_zero), 64'(e[VW]));
    check("out_any_neg", 64'(out_any_neg), 64'(e[VW+1]));
    check("done_alu_idle", 64'({alu_op, alu_a, alu_b}), 64'd0);
  endtask

  // Stall in DONE, then consume the result.
  task automatic drain(input int stall);
    logic [VW-1:0] held;
    held = out_vec;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_vec", 64'(out_vec), 64'(held));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int t0;
    int gap;
    int n;
    logic [VW-1:0] ra;
    logic [VW-1:0] rb;
    logic [2:0]    rop;
    logic [2:0]    ops [4];
    ops[0] = 3'b001;
    ops[1] = 3'b010;
    ops[2] = 3'b011;
    ops[3] = 3'b111;

    rst = 1'b1;
    in_valid = 1'b0;
    in_op = '0;
    in_vec_a = '0;
    in_vec_b = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_vec", 64'(out_vec), 64'd0);
    check("rst_flags", 64'({out_any_neg, out_all_zero}), 64'd0);
    check("rst_alu", 64'({alu_op, alu_a, alu_b}), 64'd0);

    issue(3'b010, pk(1, 2, 3, 4), pk(3, 3, 3, 3));
    check("add_vec_const", 64'(out_vec), 64'(pk(4, 5, 6, 7)));
    drain(0);

    issue(3'b011, pk(5, 5, 5, 5), pk(5, 5, 5, 5));
    check("zero_all_zero", 64'(out_all_zero), 64'd1);
    drain(1);
    issue(3'b011, pk(5, 5, 5, 6), pk(5, 5, 5, 5));
    check("zero_not_all", 64'(out_all_zero), 64'd0);
    drain(0);

    issue(3'b011, pk(1, 9, 9, 9), pk(3, 1, 1, 1));
    check("neg_vec_const", 64'(out_vec), 64'(pk(254, 8, 8, 8)));
    check("neg_flag_const", 64'(out_any_neg), 64'd1);
    drain(0);

    // Backpressure with a pending instruction upstream.
    issue(3'b010, pk(10, 20, 30, 40), pk(1, 1, 1, 1));
    in_op    = 3'b001;
    in_vec_a = pk(7, 7, 7, 7);
    in_vec_b = pk(1, 2, 3, 4);
`ifndef SIMD_SEQ_BACK_TO_BACK_EN
    in_valid = 1'b1;
`endif
    drain(10);
    check("pending_not_taken", 64'({alu_op, alu_a, alu_b}), 64'd0);
    issue(3'b001, pk(7, 7, 7, 7), pk(1, 2, 3, 4));
    drain(0);

    // Reset while lane 2 is on the ALU.
    in_op    = 3'b010;
    in_vec_a = pk(11, 22, 33, 44);
    in_vec_b = pk(1, 1, 1, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_lane2", 64'(alu_a), 64'd33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_vec", 64'(out_vec), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_alu", 64'({alu_op, alu_a, alu_b}), 64'd0);
    issue(3'b001, pk(3, 3, 3, 3), pk(2, 2, 2, 2));
    check("xor_vec_const", 64'(out_vec), 64'(pk(1, 1, 1, 1)));
    drain(0);

    // Sustained throughput with both handshakes held high.
    in_op    = 3'b111;
    in_vec_a = pk(1, 127, 255, 0);
    in_vec_b = pk(9, 9, 9, 9);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    t0 = cyc;
    check("inc_vec", 64'(out_vec), 64'(pk(2, 128, 0, 1)));
    check("inc_neg", 64'(out_any_neg), 64'd1);
    step();
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    gap = cyc - t0;
    in_valid = 1'b0;
`ifdef SIMD_SEQ_BACK_TO_BACK_EN
    check("b2b_gap", 64'(gap), 64'(L + 1));
`else
    check("b2b_gap", 64'(gap), 64'(L + 2));
`endif
    check("b2b_vec2", 64'(out_vec), 64'(pk(2, 128, 0, 1)));
    step();
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    if (out_valid) drain(0);

    for (int k = 0; k < 16; k++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = VW'($urandom);
      rb  = VW'($urandom);
      if (k == 3) rb = ra;
      issue(rop, ra, rb);
      drain($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_lane_sequencer.md
Name: simd_lane_sequencer

Overview:
- Vector issue/collect stage wrapped around the combinational `alu`.
- Accepts one SIMD instruction per handshake: an op plus two packed vectors of `lanes` elements.
- Drives the ALU one lane per cycle, then captures each lane result into a packed result vector.
- Reduces the per-lane ALU flags into vector flags and presents the result downstream with a valid/ready handshake.

Parameters:
- dataSize, 8, width of one lane element; must match `alu` dataSize.
- lanes, 4, number of elements per vector; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  sequencer can accept an instruction.
- in_op  input  3  ALU operation_select code, passed through uninterpreted.
- in_vec_a  input  lanes*dataSize  operand-1 vector; lane i = bits [i*dataSize +: dataSize].
- in_vec_b  input  lanes*dataSize  operand-2 vector, same packing.
- alu_op  output  3  to alu operation_select.
- alu_a  output  dataSize  to alu operand1.
- alu_b  output  dataSize  to alu operand2.
- alu_result  input  dataSize  from alu result.
- alu_neg  input  1  from alu negFlag.
- alu_zero  input  1  from alu zeroFlag.
- out_valid  output  1  result vector valid.
- out_ready  input  1  downstream accepts result.
- out_vec  output  lanes*dataSize  collected results, same packing.
- out_any_neg  output  1  OR of alu_neg over all lanes.
- out_all_zero  output  1  AND of alu_zero over all lanes.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - Lane counter 0; captured op/operands cleared.
  - out_vec=0, out_any_neg=0, out_all_zero=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-ISSUE or mid-DONE discards the instruction; no partial result is ever presented.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1: capture in_op, in_vec_a, in_vec_b; lane counter=0; out_vec=0; out_any_neg=0; out_all_zero=1; next state ISSUE.
- ISSUE:
  - in_ready=0.
  - alu_op=captured op; alu_a/alu_b = lane[counter] of the captured vectors. These are combinational from registers.
  - At each edge, write alu_result into out_vec lane[counter]; out_any_neg |= alu_neg; out_all_zero &= alu_zero.
  - When counter==lanes-1, next state is DONE; otherwise counter+1.
  - Lane 0 is issued first.
- DONE:
  - out_valid=1; out_vec and flags held stable while out_ready=0, for an unbounded stall.
  - When out_ready=1, next state is IDLE.
- Outside ISSUE: alu_op, alu_a and alu_b are driven 0.
- Latency: instruction accepted at edge T → out_valid=1 in the cycle after edge T+lanes, i.e. lanes+1 cycles. Throughput is one instruction per lanes+2 cycles without the optional feature.
- Width rules:
  - The ALU result is stored unmodified, with no extension.
  - Op code 111 (inc) still drives alu_b; the ALU ignores it.
- Handshakes:
  - in_valid while in_ready=0 is ignored; upstream must hold it.
  - out_ready while out_valid=0 has no effect.
- lanes=1: ISSUE lasts exactly one cycle.

Optional Feature:
- Macro SIMD_SEQ_BACK_TO_BACK_EN.
- Defined:
  - In DONE, in_ready=out_ready.
  - If out_ready=1 and in_valid=1 in the same cycle, the result is consumed, the new instruction is captured with flags re-initialised, and next state is ISSUE, skipping IDLE.
  - Throughput becomes one instruction per lanes+1 cycles.
- Undefined: in_ready=1 only in IDLE.

Test Plan (dataSize=8, lanes=4, real alu instance; lane values listed lane0..lane3):
- Add: op 010, a={1,2,3,4}, b={3,3,3,3}, accepted at edge T → out_valid first high after edge T+4; out_vec={4,5,6,7}; out_any_neg=0; out_all_zero=0.
- Zero: op 011, a=b={5,5,5,5} → out_vec={0,0,0,0}, out_all_zero=1, out_any_neg=0. Repeat with a={5,5,5,6} → out_all_zero=0.
- Negative: op 011, a={1,9,9,9}, b={3,1,1,1} → out_vec={254,8,8,8}, out_any_neg=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid stays 1, out_vec constant, in_ready=0. A pending in_valid is not accepted until one cycle after out_ready=1.
- Reset mid-op: assert rst while issuing lane 2 → next cycle state IDLE, out_valid=0, out_vec=0, in_ready=1. A fresh xor op 001 a={3,3,3,3}, b={2,2,2,2} then yields {1,1,1,1}.
- Back-to-back (macro defined): in_valid and out_ready held 1 across two instructions → second out_valid exactly 5 cycles after the first. Without the macro the gap is 6 cycles.
